// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        BLANK,
        DRIVE
    } scan_state_e;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; non-BCD codes decode to blank.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode 7-segment display with a
// blank interval before each digit and a frame-boundary load handshake.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*MAX_DIGITS-1:0] digits,
    input  logic [MAX_DIGITS-1:0]   digit_en,
    input  logic                    load_req,
    output logic                    load_ack,
    output logic [6:0]              seg,
    output logic [MAX_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0]       DwellLast = CntW'(DWELL_CYCLES - 1);
    localparam logic [CntW-1:0]       BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [2:0]            LastIdx   = 3'(NUM_DIGITS - 1);
    localparam logic [MAX_DIGITS-1:0] AnOff     = '1;
    localparam logic [MAX_DIGITS-1:0] AnBit0    = MAX_DIGITS'(1);

    scan_state_e             state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic [4*MAX_DIGITS-1:0] shadow_q, shadow_d;
    logic [MAX_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    load_ack_q, frame_done_q;
    logic                    boundary;
    logic                    do_load;
    logic [3:0]              nibble;
    logic [6:0]              dec_seg;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (cnt_q == BlankLast) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == DwellLast) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (idx_q == LastIdx) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign do_load  = boundary & load_req;
    assign shadow_d = do_load ? digits : shadow_q;

    // Outputs are computed from next state so they are valid on the first clock of each state.
    assign nibble = shadow_d[{idx_d, 2'b00} +: 4];

    bcd_to_seg u_dec (
        .bcd (nibble),
        .seg (dec_seg)
    );

    always_comb begin
        an_d  = AnOff;
        seg_d = SEG_BLANK;
        if (state_d == DRIVE) begin
            seg_d = dec_seg;
            if (digit_en[idx_d]) begin
                an_d = ~(AnBit0 << idx_d);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            an_q         <= AnOff;
            seg_q        <= SEG_BLANK;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            load_ack_q   <= do_load;
            frame_done_q <= boundary;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: a vector table for scan/load timing plus
// hand sequences for held requests, reset mid-frame and a single-digit build.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] digits = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic        load_req = 1'b0;

    logic        load_ack, frame_done;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        load_ack1, frame_done1;
    logic [6:0]  seg1;
    logic [7:0]  an1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (8),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS   (1),
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .load_req   (load_req),
        .load_ack   (load_ack1),
        .seg        (seg1),
        .an         (an1),
        .frame_done (frame_done1)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        ack;
        logic        fd;
        logic        req;
        logic [7:0]  en;
        logic [31:0] dig;
    } vec_t;

    task automatic tick();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Hold reset for n clocks, then release just after a falling edge; that point is cycle 0.
    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic wait_ack(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (load_ack === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    localparam logic [31:0] D0 = 32'h76543210;
    localparam logic [31:0] DX = 32'hFFFFFFFA;

    vec_t vecs[$];
    int   ack_at, ack_at2;
    logic saw_ack;

    initial begin
        // {cyc, an, seg, ack, frame_done | req, digit_en, digits applied after the compare}
        vecs.push_back('{0,   8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{1,   8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{2,   8'hFE, 7'b1111110, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{5,   8'hFE, 7'b1111110, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{6,   8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{8,   8'hFD, 7'b1111110, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{47,  8'h7F, 7'b1111110, 1'b0, 1'b0, 1'b1, 8'hFF, D0});
        vecs.push_back('{48,  8'hFF, 7'b0000000, 1'b1, 1'b1, 1'b0, 8'hFF, D0});
        vecs.push_back('{49,  8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'hFF, D0});
        vecs.push_back('{50,  8'hFE, 7'b1111110, 1'b0, 1'b0, 1'b0, 8'hFF, D0});
        vecs.push_back('{56,  8'hFD, 7'b0110000, 1'b0, 1'b0, 1'b0, 8'hFF, D0});
        vecs.push_back('{68,  8'hF7, 7'b1111001, 1'b0, 1'b0, 1'b0, 8'hFF, D0});
        vecs.push_back('{92,  8'h7F, 7'b1110000, 1'b0, 1'b0, 1'b0, 8'hFF, D0});
        vecs.push_back('{96,  8'hFF, 7'b0000000, 1'b0, 1'b1, 1'b1, 8'h01, DX});
        vecs.push_back('{98,  8'hFE, 7'b1111110, 1'b0, 1'b0, 1'b1, 8'h01, DX});
        vecs.push_back('{104, 8'hFF, 7'b0110000, 1'b0, 1'b0, 1'b1, 8'h01, DX});
        vecs.push_back('{144, 8'hFF, 7'b0000000, 1'b1, 1'b1, 1'b0, 8'h01, DX});
        vecs.push_back('{146, 8'hFE, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'h01, DX});
        vecs.push_back('{152, 8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'h02, DX});
        vecs.push_back('{153, 8'hFD, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'h01, DX});
        vecs.push_back('{154, 8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'h01, DX});
        vecs.push_back('{186, 8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'h01, DX});
        vecs.push_back('{188, 8'hFF, 7'b0000000, 1'b0, 1'b0, 1'b0, 8'h01, DX});

        #2;
        digits   = D0;
        load_req = 1'b1;
        digit_en = 8'hFF;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_seg", {25'd0, seg}, 32'd0);
        chk("rst_ack", {31'd0, load_ack}, 32'd0);
        reset = 1'b1;
        cyc = 0;

        foreach (vecs[k]) begin
            while (cyc < vecs[k].cyc) tick();
            chk($sformatf("vec%0d_an", k), {24'd0, an}, {24'd0, vecs[k].an});
            chk($sformatf("vec%0d_seg", k), {25'd0, seg}, {25'd0, vecs[k].seg});
            chk($sformatf("vec%0d_ack", k), {31'd0, load_ack}, {31'd0, vecs[k].ack});
            chk($sformatf("vec%0d_fd", k), {31'd0, frame_done}, {31'd0, vecs[k].fd});
            load_req = vecs[k].req;
            digit_en = vecs[k].en;
            digits   = vecs[k].dig;
        end

        // Request held across two boundaries with data changed in between.
        load_req = 1'b0;
        digit_en = 8'hFF;
        do_reset(3);
        digits   = 32'h11111111;
        load_req = 1'b1;
        wait_ack(60, ack_at);
        chk("held_ack1_cyc", ack_at, 48);
        chk("held_fd1", {31'd0, frame_done}, 32'd1);
        digits = 32'h22222222;
        while (cyc < 50) tick();
        chk("held_seg1", {25'd0, seg}, {25'd0, 7'b0110000});
        wait_ack(60, ack_at2);
        chk("held_ack_gap", ack_at2 - ack_at, 48);
        load_req = 1'b0;
        while (cyc < 98) tick();
        chk("held_an2", {24'd0, an}, 32'hFE);
        chk("held_seg2", {25'd0, seg}, {25'd0, 7'b1101101});

        // Reset inside digit 3 DRIVE with a request pending.
        do_reset(3);
        digits   = 32'h99999999;
        load_req = 1'b1;
        while (cyc < 20) tick();
        chk("mid_an_pre", {24'd0, an}, 32'hF7);
        chk("mid_seg_pre", {25'd0, seg}, {25'd0, 7'b1111110});
        reset = 1'b0;
        #1;
        chk("mid_an_rst", {24'd0, an}, 32'hFF);
        chk("mid_seg_rst", {25'd0, seg}, 32'd0);
        tick();
        tick();
        chk("mid_ack_rst", {31'd0, load_ack}, 32'd0);
        load_req = 1'b0;
        reset = 1'b1;
        cyc = 0;
        saw_ack = 1'b0;
        while (cyc < 48) begin
            tick();
            if (load_ack === 1'b1) saw_ack = 1'b1;
            chk("one_an", {24'd0, an1}, (cyc % 6 < 2) ? 32'hFF : 32'hFE);
            chk("one_fd", {31'd0, frame_done1}, (cyc % 6 == 0) ? 32'd1 : 32'd0);
            if (cyc == 2) begin
                chk("mid_restart_an", {24'd0, an}, 32'hFE);
                chk("mid_shadow_clr", {25'd0, seg}, {25'd0, 7'b1111110});
            end
        end
        chk("mid_no_ack", {31'd0, saw_ack}, 32'd0);
        chk("mid_fd", {31'd0, frame_done}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display. It latches a packed BCD frame from a requester at frame boundaries, then cycles through the digits. For each digit it inserts an anti-ghosting blank interval, then drives the decoded segment pattern and the matching active-low anode. It sits between the counter/application logic and the display pins, replacing the single static digit drive.

## Interface
- `NUM_DIGITS`, default 8: number of scanned digits, 1..8. Anodes at and above `NUM_DIGITS` stay high.
- `DWELL_CYCLES`, default 50000: clocks each digit is driven, ≥1.
- `BLANK_CYCLES`, default 4: clocks all anodes are off before each digit, ≥1.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: reset is asynchronous and active-low.
- `digits` in 32: packed BCD, digit i = `digits[4i+3:4i]`.
- `digit_en` in 8: per-digit enable. 0 keeps that digit's anode off during its slot.
- `load_req` in 1: level request to latch `digits` into the shadow frame.
- `load_ack` out 1: one-cycle pulse when `digits` is captured.
- `seg` out 7: segments, active-high, `seg[6]`=a … `seg[0]`=g.
- `an` out 8: anodes, active-low.
- `frame_done` out 1: one-cycle pulse at the end of each full scan.

## Operation
- **State machine:**
  - `BLANK` lasts `BLANK_CYCLES` clocks, then goes to `DRIVE`.
  - `DRIVE` lasts `DWELL_CYCLES` clocks, then goes to `BLANK` with the digit index advanced.
  - The index wraps from `NUM_DIGITS-1` to 0.
- **BLANK outputs:** `an`=8'hFF, `seg`=7'b0000000.
- **DRIVE outputs:**
  - `an` = ~(8'b1 << idx) if `digit_en[idx]`, else 8'hFF.
  - `seg` = decode(shadow nibble idx).
- **Decode:** BCD 0–9 gives 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10–15 give 0000000 (blank).
- **Frame boundary:** the DRIVE→BLANK transition of digit `NUM_DIGITS-1`. On that transition `frame_done`=1 for one cycle.
- **Load handshake:**
  - If `load_req`=1 at a frame boundary: shadow ← `digits`, and `load_ack`=1 in the same cycle as `frame_done`.
  - The requester holds `digits` stable while `load_req` is high and drops `load_req` after seeing `load_ack`.
  - If `load_req` is still high at the next boundary, the controller reloads and acks again.
  - `load_req` low: the shadow frame is retained.
- **Reset values:** state `BLANK`, index 0, counter 0, shadow frame 0, `an`=8'hFF, `seg`=0, `load_ack`=0, `frame_done`=0.
- **Reset mid-operation:** all of the above take effect immediately. Any pending request is dropped unacked and the requester re-waits for the next boundary.
- **Live inputs:** `digit_en` is sampled live every DRIVE cycle, so a change takes effect on the next clock. `digits` is never used directly, only via the shadow frame.

## Timing
- All outputs are registered and reflect the current state from the first clock of that state.
- Per-digit slot = `BLANK_CYCLES` + `DWELL_CYCLES` clocks.
- Frame = `NUM_DIGITS` × slot clocks.
- First DRIVE of digit 0 starts `BLANK_CYCLES` clocks after reset release.
- Load latency: from `load_req` rising to `load_ack`, at most one frame.
  - New data first appears on digit 0 in the DRIVE following the ack, `BLANK_CYCLES` later.
- Counter width = clog2(max(`DWELL_CYCLES`, `BLANK_CYCLES`)).
- Counter terminal = parameter − 1. There is no off-by-one: a `DWELL_CYCLES`=1 slot drives exactly one clock.

## Structure
- Shared package `seg_pkg`:
  - the `SEG_*` segment constants for 0–9 and blank;
  - the scan-state enum (`BLANK`, `DRIVE`);
  - `MAX_DIGITS`=8.
- Sub-module `bcd_to_seg`: combinational 4-bit → 7-bit decoder using the package constants, with a default branch giving blank. It is instantiated once on the muxed shadow nibble.
- Top-level `seg_scan_ctrl` contains the FSM, the slot counter, the index register, the shadow register and the handshake logic.

## Test plan
All scenarios use `DWELL_CYCLES`=4, `BLANK_CYCLES`=2, `NUM_DIGITS`=8.
- **Reset:** hold `reset`=0 for 3 clocks → `an`=FF, `seg`=0, `load_ack`=0. After release, `an`=FF for 2 clocks, then `an`=FE for 4 clocks with `seg`=1111110 (shadow 0).
- **Load:** `digits`=32'h76543210, `load_req`=1 → `load_ack` and `frame_done` pulse together at cycle 48. Next frame: digit 3 slot shows `an`=F7, `seg`=1111001; digit 7 shows `an`=7F, `seg`=1110000.
- **Invalid codes and masking:** `digits`=32'hFFFFFFFA, `digit_en`=8'h01 → digit 0 shows `an`=FE, `seg`=0000000. Digits 1–7 show `an`=FF throughout.
- **Held request:** hold `load_req` through two boundaries, changing `digits` from 32'h11111111 to 32'h22222222 between them → two acks 48 cycles apart. The second frame shows `seg`=1101101.
- **Reset mid-operation:** `load_req`=1 and assert `reset` at cycle 20 (inside digit 3 DRIVE) → immediate `an`=FF. No `load_ack`. Shadow cleared. After release, scanning restarts at digit 0.
- **Single digit:** `NUM_DIGITS`=1 → `frame_done` every 6 cycles. `an` only ever FE or FF.
